multi_alarm_clock: RTL

- Next-generation time-of-day block: 24 h clock with a single system clock and an internal 1 Hz tick prescaler, replacing the separate 1 s clock input.
- Holds NUM_ALARMS independently enabled hh:mm alarms in a register file.
- Ring/snooze/auto-off state machine drives the buzzer.
- Time is output in binary and packed BCD for the display/7-segment stage.

---
 rtl/multi_alarm_clock.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: 24 h time-of-day counter with internal 1 Hz prescaler,
// NUM_ALARMS hh:mm alarm slots and a ring/snooze/auto-off buzzer FSM.
module multi_alarm_clock #(
  parameter int unsigned TICK_DIV       = 50000000,
  parameter int unsigned NUM_ALARMS     = 4,
  parameter int unsigned AW             = 2,
  parameter int unsigned SNOOZE_S       = 300,
  parameter int unsigned RING_TIMEOUT_S = 60
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          set_time,
  input  logic          set_hh,
  input  logic          set_mm,
  input  logic          inc_btn,
  input  logic          alarm_wr,
  input  logic [AW-1:0] alarm_sel,
  input  logic [4:0]    alarm_hh_in,
  input  logic [5:0]    alarm_mm_in,
  input  logic          alarm_en_in,
  input  logic          snooze,
  input  logic          stop,
  output logic          tick,
  output logic [4:0]    hh,
  output logic [5:0]    mm,
  output logic [5:0]    ss,
  output logic [7:0]    hh_bcd,
  output logic [7:0]    mm_bcd,
  output logic [7:0]    ss_bcd,
  output logic          buzzer,
  output logic [AW-1:0] ringing_id,
  output logic          wr_err
);

  localparam int unsigned PW  = $clog2(TICK_DIV);
  localparam int unsigned SW  = ($clog2(SNOOZE_S + 1) < 1) ? 1 : $clog2(SNOOZE_S + 1);
  localparam int unsigned RW  = ($clog2(RING_TIMEOUT_S + 1) < 1) ? 1 : $clog2(RING_TIMEOUT_S + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_S);
  localparam logic [RW-1:0] RING_MAX  = RW'(RING_TIMEOUT_S);

  typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} state_e;

  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    hh_q, hh_d;
  logic [5:0]    mm_q, mm_d, ss_q, ss_d;
  logic          inc_prev_q, inc_prev_d;
  logic          slot_en_q [NUM_ALARMS];
  logic          slot_en_d [NUM_ALARMS];
  logic [4:0]    slot_hh_q [NUM_ALARMS];
  logic [4:0]    slot_hh_d [NUM_ALARMS];
  logic [5:0]    slot_mm_q [NUM_ALARMS];
  logic [5:0]    slot_mm_d [NUM_ALARMS];
  state_e        state_q, state_d;
  logic [RW-1:0] ring_tmr_q, ring_tmr_d;
  logic [SW-1:0] snz_tmr_q, snz_tmr_d;
  logic          buzzer_q, buzzer_d;
  logic [AW-1:0] ring_id_q, ring_id_d;
  logic          wr_err_q, wr_err_d;

  logic          tick_w, count_tick, inc_edge, roll, wr_bad;
  logic          match_hit;
  logic [AW-1:0] match_id;

  // Prescaler, time counting and manual set
  always_comb begin
    tick_w     = (presc_q == PRESC_MAX);
    presc_d    = tick_w ? '0 : presc_q + 1'b1;
    inc_edge   = inc_btn & ~inc_prev_q;
    inc_prev_d = inc_btn;
    count_tick = tick_w & ~set_time;
    roll       = count_tick & (ss_q == 6'd59);
    hh_d       = hh_q;
    mm_d       = mm_q;
    ss_d       = ss_q;
    if (count_tick) begin
      if (ss_q == 6'd59) begin
        ss_d = '0;
        if (mm_q == 6'd59) begin
          mm_d = '0;
          hh_d = (hh_q == 5'd23) ? '0 : hh_q + 1'b1;
        end else begin
          mm_d = mm_q + 1'b1;
        end
      end else begin
        ss_d = ss_q + 1'b1;
      end
    end else if (set_time && inc_edge) begin
      if (set_hh) begin
        hh_d = (hh_q == 5'd23) ? '0 : hh_q + 1'b1;
        ss_d = '0;
      end else if (set_mm) begin
        mm_d = (mm_q == 6'd59) ? '0 : mm_q + 1'b1;
        ss_d = '0;
      end
    end
  end

  // Alarm register file write with range validation
  always_comb begin
    wr_bad   = (alarm_hh_in > 5'd23) || (alarm_mm_in > 6'd59) ||
               ({1'b0, alarm_sel} >= (AW+1)'(NUM_ALARMS));
    wr_err_d = alarm_wr & wr_bad;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      slot_en_d[i] = slot_en_q[i];
      slot_hh_d[i] = slot_hh_q[i];
      slot_mm_d[i] = slot_mm_q[i];
      if (alarm_wr && !wr_bad && (alarm_sel == AW'(i))) begin
        slot_en_d[i] = alarm_en_in;
        slot_hh_d[i] = alarm_hh_in;
        slot_mm_d[i] = alarm_mm_in;
      end
    end
  end

  // Alarm match against the new time on a minute rollover; lowest slot wins
  always_comb begin
    match_hit = 1'b0;
    match_id  = '0;
    if (roll) begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        if (!match_hit && slot_en_q[i] && (slot_hh_q[i] == hh_d) && (slot_mm_q[i] == mm_d)) begin
          match_hit = 1'b1;
          match_id  = AW'(i);
        end
      end
    end
  end

  // Ring / snooze / auto-off next-state logic
  always_comb begin
    state_d    = state_q;
    ring_tmr_d = ring_tmr_q;
    snz_tmr_d  = snz_tmr_q;
    ring_id_d  = ring_id_q;
    unique case (state_q)
      ST_IDLE: begin
        if (match_hit) begin
          state_d    = ST_RING;
          ring_id_d  = match_id;
          ring_tmr_d = '0;
        end
      end
      ST_RING: begin
        if (tick_w) ring_tmr_d = ring_tmr_q + 1'b1;
        if (stop) begin
          state_d = ST_IDLE;
        end else if (snooze) begin
          state_d   = ST_SNOOZE;
          snz_tmr_d = SNZ_LOAD;
        end else if (tick_w && (ring_tmr_q + 1'b1 == RING_MAX)) begin
          state_d = ST_IDLE;
        end
      end
      ST_SNOOZE: begin
        if (tick_w) snz_tmr_d = snz_tmr_q - 1'b1;
        if (stop) begin
          state_d = ST_IDLE;
        end else if (match_hit) begin
          state_d    = ST_RING;
          ring_id_d  = match_id;
          ring_tmr_d = '0;
        end else if (tick_w && (snz_tmr_q - 1'b1 == '0)) begin
          state_d    = ST_RING;
          ring_tmr_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    buzzer_d = (state_d == ST_RING);
  end

  // All state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!RST) begin
      presc_q    <= '0;
      hh_q       <= '0;
      mm_q       <= '0;
      ss_q       <= '0;
      inc_prev_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        slot_en_q[i] <= 1'b0;
        slot_hh_q[i] <= '0;
        slot_mm_q[i] <= '0;
      end
      state_q    <= ST_IDLE;
      ring_tmr_q <= '0;
      snz_tmr_q  <= '0;
      buzzer_q   <= 1'b0;
      ring_id_q  <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      inc_prev_q <= inc_prev_d;
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        slot_en_q[i] <= slot_en_d[i];
        slot_hh_q[i] <= slot_hh_d[i];
        slot_mm_q[i] <= slot_mm_d[i];
      end
      state_q    <= state_d;
      ring_tmr_q <= ring_tmr_d;
      snz_tmr_q  <= snz_tmr_d;
      buzzer_q   <= buzzer_d;
      ring_id_q  <= ring_id_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // Output mapping and BCD conversion
  always_comb begin
    tick       = tick_w;
    hh         = hh_q;
    mm         = mm_q;
    ss         = ss_q;
    hh_bcd     = {4'(hh_q / 5'd10), 4'(hh_q % 5'd10)};
    mm_bcd     = {4'(mm_q / 6'd10), 4'(mm_q % 6'd10)};
    ss_bcd     = {4'(ss_q / 6'd10), 4'(ss_q % 6'd10)};
    buzzer     = buzzer_q;
    ringing_id = ring_id_q;
    wr_err     = wr_err_q;
  end

endmodule
